// File: rtl/ttl_register_bank.sv
// ============================================================================
// ttl_register_bank
// ----------------------------------------------------------------------------
// Purpose:
//   A bank of BLOCKS independent WIDTH-bit universal registers. Each channel
//   behaves like a 74194: hold, shift right, shift left or parallel load,
//   selected per channel. Each channel also has a synchronous preset that
//   fires once per falling edge of Preset_bar. A shared synchronous
//   active-low Clear_bar resets every channel. All state changes happen on
//   the rising edge of Clk; there are no asynchronous paths.
//
//   Priority per channel: Clear_bar > preset edge > Mode.
//
//   Bit 0 of a channel is the first stage:
//     shift right : Q[k] <= Q[k-1], Q[0] <= serial-right input
//     shift left  : Q[k] <= Q[k+1], Q[WIDTH-1] <= serial-left input
//
// Optional feature (macro TTL_REGISTER_BANK_CASCADE_EN):
//   When defined, the serial-right input of channel i>0 is the top bit of
//   channel i-1, and the serial-left input of channel i<BLOCKS-1 is bit 0 of
//   channel i+1 (both taken before the edge). Channel 0 keeps DSR[0] and
//   channel BLOCKS-1 keeps DSL[BLOCKS-1]; the other DSR/DSL bits are unused.
//   When undefined, every channel uses its own DSR[i]/DSL[i].
//
// Parameters:
//   BLOCKS      number of channels (>=1)
//   WIDTH       bits per channel (>=1)
//   DELAY_RISE  simulation-only rise delay on Q/Q_bar (not modelled here;
//               the synthesizable outputs change directly after the edge)
//   DELAY_FALL  simulation-only fall delay on Q/Q_bar (as above)
//
// Ports:
//   Clk         in   1              clock, rising edge active
//   Clear_bar   in   1              synchronous active-low clear, all channels
//   Preset_bar  in   BLOCKS         per-channel preset request (falling edge)
//   Mode        in   2*BLOCKS       channel i mode at [2i+1:2i]
//                                   00 hold, 01 shift right, 10 shift left,
//                                   11 load
//   D           in   BLOCKS*WIDTH   load data, channel i at [i*WIDTH +: WIDTH]
//   DSR         in   BLOCKS         shift-right serial input per channel
//   DSL         in   BLOCKS         shift-left serial input per channel
//   Q           out  BLOCKS*WIDTH   register contents, same packing as D
//   Q_bar       out  BLOCKS*WIDTH   bitwise complement of Q
// ============================================================================
module ttl_register_bank #(
   parameter int BLOCKS     = 2,
   parameter int WIDTH      = 4,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                     Clk,
   input  logic                     Clear_bar,
   input  logic [BLOCKS-1:0]        Preset_bar,
   input  logic [2*BLOCKS-1:0]      Mode,
   input  logic [BLOCKS*WIDTH-1:0]  D,
   input  logic [BLOCKS-1:0]        DSR,
   input  logic [BLOCKS-1:0]        DSL,
   output logic [BLOCKS*WIDTH-1:0]  Q,
   output logic [BLOCKS*WIDTH-1:0]  Q_bar
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   // -------------------------------------------------------------------------
   // Elaboration-time parameter sanity checks
   // -------------------------------------------------------------------------
   if (BLOCKS < 1) begin : g_bad_blocks
      $error("ttl_register_bank: BLOCKS must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("ttl_register_bank: WIDTH must be >= 1");
   end
   if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
      $error("ttl_register_bank: DELAY_RISE/DELAY_FALL must be >= 0");
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [BLOCKS*WIDTH-1:0] q_q;
   logic [BLOCKS*WIDTH-1:0] q_d;
   // Last sampled Preset_bar per channel; reset to ones so a Preset_bar that
   // is already low on the first edge after clear counts as a falling edge.
   logic [BLOCKS-1:0]       hist_q;
   logic [BLOCKS-1:0]       hist_d;

   logic [BLOCKS-1:0]       sr_in;
   logic [BLOCKS-1:0]       sl_in;
   logic [BLOCKS-1:0]       preset_fire;

   // -------------------------------------------------------------------------
   // Shift helpers. Written with shifts plus a single-bit overwrite so that
   // WIDTH=1 degenerates to "load the serial bit" without zero-width slices.
   // -------------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                    input logic             s);
      logic [WIDTH-1:0] r;
      r    = v << 1;
      r[0] = s;
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                   input logic             s);
      logic [WIDTH-1:0] r;
      r          = v >> 1;
      r[WIDTH-1] = s;
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // Serial input selection
   // -------------------------------------------------------------------------
   for (genvar i = 0; i < BLOCKS; i++) begin : g_serial
`ifdef TTL_REGISTER_BANK_CASCADE_EN
      if (i == 0) begin : g_sr_ext
         assign sr_in[i] = DSR[i];
      end else begin : g_sr_chain
         logic unused_dsr;
         // Top bit of the lower channel feeds this channel's first stage.
         assign sr_in[i]   = q_q[i*WIDTH-1];
         assign unused_dsr = DSR[i];
      end
      if (i == BLOCKS-1) begin : g_sl_ext
         assign sl_in[i] = DSL[i];
      end else begin : g_sl_chain
         logic unused_dsl;
         // Bit 0 of the upper channel feeds this channel's last stage.
         assign sl_in[i]   = q_q[(i+1)*WIDTH];
         assign unused_dsl = DSL[i];
      end
`else
      assign sr_in[i] = DSR[i];
      assign sl_in[i] = DSL[i];
`endif
   end

   // A preset fires when Preset_bar is sampled low while the previous sample
   // was high; a held-low request therefore fires only once.
   assign preset_fire = hist_q & ~Preset_bar;

   // -------------------------------------------------------------------------
   // Next-state logic (Clear_bar handled in the register process)
   // -------------------------------------------------------------------------
   always_comb begin
      q_d    = q_q;
      hist_d = Preset_bar;
      for (int i = 0; i < BLOCKS; i++) begin
         if (preset_fire[i]) begin
            q_d[i*WIDTH +: WIDTH] = '1;
         end else begin
            case (Mode[2*i +: 2])
               MODE_HOLD: q_d[i*WIDTH +: WIDTH] = q_q[i*WIDTH +: WIDTH];
               MODE_SHR:  q_d[i*WIDTH +: WIDTH] =
                             shift_right(q_q[i*WIDTH +: WIDTH], sr_in[i]);
               MODE_SHL:  q_d[i*WIDTH +: WIDTH] =
                             shift_left(q_q[i*WIDTH +: WIDTH], sl_in[i]);
               MODE_LOAD: q_d[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
               default:   q_d[i*WIDTH +: WIDTH] = q_q[i*WIDTH +: WIDTH];
            endcase
         end
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         q_q    <= '0;
         hist_q <= '1;
      end else begin
         q_q    <= q_d;
         hist_q <= hist_d;
      end
   end

   assign Q     = q_q;
   assign Q_bar = ~q_q;

endmodule

// File: tb/tb_ttl_register_bank.sv
// ============================================================================
// tb_ttl_register_bank
// ----------------------------------------------------------------------------
// Bench for ttl_register_bank with BLOCKS=2, WIDTH=4. A behavioural model
// (integer arithmetic on per-channel nibbles) predicts Q after every edge;
// directed steps cover clear, load/hold, shifting, preset edge behaviour,
// clear priority and the serial chaining, followed by random traffic.
// ============================================================================
module tb_ttl_register_bank;

   localparam int BLOCKS = 2;
   localparam int WIDTH  = 4;

   // -------------------------------------------------------------------------
   // Clock / DUT signals
   // -------------------------------------------------------------------------
   logic                    Clk = 1'b0;
   logic                    Clear_bar;
   logic [BLOCKS-1:0]       Preset_bar;
   logic [2*BLOCKS-1:0]     Mode;
   logic [BLOCKS*WIDTH-1:0] D;
   logic [BLOCKS-1:0]       DSR;
   logic [BLOCKS-1:0]       DSL;
   logic [BLOCKS*WIDTH-1:0] Q;
   logic [BLOCKS*WIDTH-1:0] Q_bar;

   always #5 Clk = ~Clk;

   ttl_register_bank #(
      .BLOCKS     (BLOCKS),
      .WIDTH      (WIDTH),
      .DELAY_RISE (0),
      .DELAY_FALL (0)
   ) dut (
      .Clk        (Clk),
      .Clear_bar  (Clear_bar),
      .Preset_bar (Preset_bar),
      .Mode       (Mode),
      .D          (D),
      .DSR        (DSR),
      .DSL        (DSL),
      .Q          (Q),
      .Q_bar      (Q_bar)
   );

   // -------------------------------------------------------------------------
   // Reference model: channel values as integers 0..15, preset history bits
   // -------------------------------------------------------------------------
   int m_q[BLOCKS];
   int m_h[BLOCKS];

   int n_pass  = 0;
   int n_total = 0;

   task automatic model_edge();
      int old_q[BLOCKS];
      int sr;
      int sl;
      int md;
      for (int c = 0; c < BLOCKS; c++) old_q[c] = m_q[c];
      for (int c = 0; c < BLOCKS; c++) begin
         if (Clear_bar !== 1'b1) begin
            m_q[c] = 0;
            m_h[c] = 1;
         end else begin
            sr = int'(DSR[c]);
            sl = int'(DSL[c]);
`ifdef TTL_REGISTER_BANK_CASCADE_EN
            if (c > 0)        sr = (old_q[c-1] / 8) % 2;
            if (c < BLOCKS-1) sl = old_q[c+1] % 2;
`endif
            md = int'(Mode[2*c +: 2]);
            if (m_h[c] == 1 && Preset_bar[c] == 1'b0) begin
               m_q[c] = 15;
            end else if (md == 1) begin
               m_q[c] = (old_q[c] * 2 + sr) % 16;
            end else if (md == 2) begin
               m_q[c] = old_q[c] / 2 + sl * 8;
            end else if (md == 3) begin
               m_q[c] = int'(D[c*WIDTH +: WIDTH]);
            end
            m_h[c] = int'(Preset_bar[c]);
         end
      end
   endtask

   function automatic logic [7:0] model_q();
      return {m_q[1][3:0], m_q[0][3:0]};
   endfunction

   // -------------------------------------------------------------------------
   // Checking helpers
   // -------------------------------------------------------------------------
   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One rising edge: update the model from the inputs present at the edge,
   // then sample the DUT 1 time unit later.
   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check(tag, Q, model_q());
      check({tag, "_qbar"}, Q_bar, ~model_q());
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      for (int c = 0; c < BLOCKS; c++) begin
         m_q[c] = 0;
         m_h[c] = 1;
      end

      // Clear with everything else active
      Clear_bar  = 1'b0;
      D          = 8'hFF;
      Mode       = 4'hF;
      Preset_bar = 2'b00;
      DSR        = 2'b00;
      DSL        = 2'b00;
      step("clear1");
      step("clear2");
      check("clear_q_const", Q, 8'h00);
      check("clear_qbar_const", Q_bar, 8'hFF);

      Clear_bar  = 1'b1;
      Preset_bar = 2'b11;
      step("first_load");
      check("first_load_const", Q, 8'hFF);

      // Load then hold with changing D
      D    = 8'hA5;
      Mode = 4'hF;
      step("load_a5");
      check("load_a5_const", Q, 8'hA5);
      Mode = 4'h0;
      for (int k = 0; k < 3; k++) begin
         D = 8'($urandom);
         step("hold");
         check("hold_const", Q, 8'hA5);
      end

      // Channel 0 load 5, then shift right with DSR 1,0,1,1 and shift left
      Mode = 4'b0011;
      D    = 8'h05;
      step("ch0_load5");
      Mode = 4'b0001;
      DSR  = 2'b01; step("shr1"); check("shr1_const", Q, 8'hAB);
      DSR  = 2'b00; step("shr2"); check("shr2_const", Q, 8'hA6);
      DSR  = 2'b01; step("shr3"); check("shr3_const", Q, 8'hAD);
      DSR  = 2'b01; step("shr4"); check("shr4_const", Q, 8'hAB);
      Mode = 4'b0010;
      DSL  = 2'b00; step("shl1"); check("shl1_const", Q, 8'hA5);

      // Preset edge detection on channel 1
      Preset_bar = 2'b11;
      Clear_bar  = 1'b0;
      step("pre_clear");
      Clear_bar  = 1'b1;
      Mode       = 4'b0000;
      step("pre_idle");
      Preset_bar = 2'b01;
      Mode       = 4'b1100;
      D          = 8'h30;
      step("preset_e1"); check("preset_e1_const", Q, 8'hF0);
      step("preset_e2"); check("preset_e2_const", Q, 8'h30);
      step("preset_e3"); check("preset_e3_const", Q, 8'h30);
      Preset_bar = 2'b11;
      step("preset_rel");
      Preset_bar = 2'b01;
      step("preset_re"); check("preset_re_const", Q, 8'hF0);

      // Clear wins over a simultaneous preset edge and load
      Preset_bar = 2'b11;
      Mode       = 4'b0000;
      step("coll_idle");
      Clear_bar  = 1'b0;
      Preset_bar = 2'b00;
      Mode       = 4'hF;
      D          = 8'hFF;
      step("coll_clear"); check("coll_clear_const", Q, 8'h00);
      Clear_bar  = 1'b1;
      Mode       = 4'h0;
      step("coll_after"); check("coll_after_const", Q, 8'hFF);
      Preset_bar = 2'b11;

      // Clear in the middle of a shift sequence, then resume
      Mode = 4'b0101;
      DSR  = 2'b11;
      step("mid_shift1");
      step("mid_shift2");
      Clear_bar = 1'b0;
      step("mid_clear"); check("mid_clear_const", Q, 8'h00);
      Clear_bar = 1'b1;
      step("mid_resume1");
      step("mid_resume2");

      // Cross-channel shifting
      Mode = 4'hF;
      D    = 8'h80;
      DSR  = 2'b00;
      DSL  = 2'b00;
      step("casc_load80");
      Mode = 4'b0101;
      step("casc_shift80"); check("casc_shift80_const", Q, 8'h00);
      Mode = 4'hF;
      D    = 8'h08;
      step("casc_load08");
      Mode = 4'b0101;
      step("casc_shift08");
`ifdef TTL_REGISTER_BANK_CASCADE_EN
      check("casc_shift08_const", Q, 8'h10);
`else
      check("casc_shift08_const", Q, 8'h00);
`endif
      Mode = 4'hF;
      D    = 8'h10;
      step("casc_load10");
      Mode = 4'b1010;
      step("casc_shl10");
`ifdef TTL_REGISTER_BANK_CASCADE_EN
      check("casc_shl10_const", Q, 8'h08);
`else
      check("casc_shl10_const", Q, 8'h00);
`endif

      // Random traffic against the model
      for (int k = 0; k < 300; k++) begin
         Clear_bar  = ($urandom_range(0, 19) != 0);
         Preset_bar = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
         Mode       = 4'($urandom);
         D          = 8'($urandom);
         DSR        = 2'($urandom);
         DSL        = 2'($urandom);
         step("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
